// File: rtl/run_controller_pkg.sv
// Shared state encoding and default limits for the run/halt sequencer.
package run_controller_pkg;

    localparam int unsigned StateW             = 3;
    localparam int unsigned DefaultCycleW      = 16;
    localparam int unsigned DefaultMaxCycles   = 850;
    localparam int unsigned DefaultDrainCycles = 4;

    typedef enum logic [StateW-1:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StDrain   = 3'd2,
        StHalted  = 3'd3,
        StTimeout = 3'd4
    } run_state_e;

endpackage

// File: rtl/run_controller_if.sv
// Control/status bundle between the run controller and its clock/testbench wrapper.
interface run_controller_if #(
    parameter int unsigned CYCLE_W = run_controller_pkg::DefaultCycleW
);
    import run_controller_pkg::*;

    logic                start;
    logic                step_mode;
    logic                step_pulse;
    logic                halt_req;
    logic                run_en;
    logic                halt;
    logic                timeout;
    logic [CYCLE_W-1:0]  cycles;
    logic [StateW-1:0]   state;

    // Wrapper side: issues run requests, observes status.
    modport master (
        output start, step_mode, step_pulse, halt_req,
        input  run_en, halt, timeout, cycles, state
    );

    // Controller side.
    modport slave (
        input  start, step_mode, step_pulse, halt_req,
        output run_en, halt, timeout, cycles, state
    );

endinterface

// File: rtl/run_controller_cycle_watchdog.sv
// Executed-cycle counter that freezes at the watchdog limit and flags the limit-reaching edge.
module run_controller_cycle_watchdog
    import run_controller_pkg::*;
#(
    parameter int unsigned CYCLE_W    = DefaultCycleW,
    parameter int unsigned MAX_CYCLES = DefaultMaxCycles
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    output logic [CYCLE_W-1:0] count_o,
    output logic               limit_hit_o
);

    localparam logic [CYCLE_W-1:0] Limit     = CYCLE_W'(MAX_CYCLES);
    localparam logic [CYCLE_W-1:0] LimitLast = CYCLE_W'(MAX_CYCLES - 1);

    logic [CYCLE_W-1:0] count_d, count_q;

    // Count enabled cycles; hold at the limit so the value never wraps.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != Limit)) begin
            count_d = count_q + CYCLE_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High on the edge that will move the count onto the limit.
    always_comb begin
        limit_hit_o = en_i && (count_q == LimitLast);
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_controller.sv
// Run/halt sequencer: start, optional single-step, post-halt pipeline drain and cycle watchdog.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int unsigned CYCLE_W      = DefaultCycleW,
    parameter int unsigned MAX_CYCLES   = DefaultMaxCycles,
    parameter int unsigned DRAIN_CYCLES = DefaultDrainCycles
) (
    input  logic           clk,
    input  logic           reset,
    run_controller_if.slave bus
);

    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

    run_state_e          state_d, state_q;
    logic [DrainW-1:0]   drain_d, drain_q;
    logic                halt_d, halt_q;
    logic                timeout_d, timeout_q;
    logic                run_en;
    logic                limit_hit;
    logic [CYCLE_W-1:0]  cycles;

    run_controller_cycle_watchdog #(
        .CYCLE_W    (CYCLE_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_cycle_watchdog (
        .clk         (clk),
        .reset       (reset),
        .en_i        (run_en),
        .count_o     (cycles),
        .limit_hit_o (limit_hit)
    );

    // Pipeline advance enable; in step mode only a pulse advances the pipeline.
    always_comb begin
        run_en = 1'b0;
        unique case (state_q)
            StRun:   run_en = bus.step_mode ? bus.step_pulse : 1'b1;
            StDrain: run_en = 1'b1;
            default: run_en = 1'b0;
        endcase
    end

    // Next state; the watchdog outranks both halt acceptance and drain completion.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StRun;
            end
            StRun: begin
                // halt_req only counts on an advancing cycle.
                if (run_en) begin
                    if (limit_hit) begin
                        state_d = StTimeout;
                    end else if (bus.halt_req) begin
                        state_d = StDrain;
                        drain_d = DrainLoad;
                    end
                end
            end
            StDrain: begin
                if (limit_hit) begin
                    state_d = StTimeout;
                end else if (drain_q == '0) begin
                    state_d = StHalted;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            StHalted, StTimeout: begin
                state_d = state_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Status follows the next state so it rises together with the state change.
        halt_d    = (state_d == StHalted) || (state_d == StTimeout);
        timeout_d = (state_d == StTimeout);
    end

    // FSM, drain counter and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            drain_q   <= '0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            halt_q    <= halt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.run_en  = run_en;
    assign bus.halt    = halt_q;
    assign bus.timeout = timeout_q;
    assign bus.cycles  = cycles;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus randomized run against a model.
module tb_run_controller;

    localparam int unsigned CycleW   = 16;
    localparam int          MaxCyc   = 850;
    localparam int          DrainCyc = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    run_controller_if #(.CYCLE_W(CycleW)) bus ();

    run_controller #(
        .CYCLE_W      (CycleW),
        .MAX_CYCLES   (MaxCyc),
        .DRAIN_CYCLES (DrainCyc)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 run, 2 drain, 3 halted, 4 timeout.
    int m_state      = 0;
    int m_cycles     = 0;
    int m_drain_left = 0;
    bit m_valid      = 1'b0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_run_en(input bit sm, input bit sp);
        return ((m_state == 1) && (!sm || sp)) || (m_state == 2);
    endfunction

    task automatic model_step(input bit st, input bit hr, input bit rs, input bit ren);
        bit hit;
        if (rs) begin
            m_state      = 0;
            m_cycles     = 0;
            m_drain_left = 0;
            m_valid      = 1'b1;
            return;
        end
        hit = ren && (m_cycles == MaxCyc - 1);
        if (ren && (m_cycles < MaxCyc)) m_cycles++;
        case (m_state)
            0: if (st) m_state = 1;
            1: if (ren) begin
                if (hit) m_state = 4;
                else if (hr) begin
                    m_state      = 2;
                    m_drain_left = DrainCyc;
                end
            end
            2: begin
                m_drain_left--;
                if (hit) m_state = 4;
                else if (m_drain_left == 0) m_state = 3;
            end
            default: ;
        endcase
    endtask

    // One clock: drive inputs, check run_en, clock, advance model, check registered outputs.
    task automatic cycle(input bit st, input bit sm, input bit sp, input bit hr, input bit rs);
        bit ren;
        reset          = rs;
        bus.start      = st;
        bus.step_mode  = sm;
        bus.step_pulse = sp;
        bus.halt_req   = hr;
        #1;
        ren = model_run_en(sm, sp);
        if (m_valid) check_val("run_en", bus.run_en, ren);
        @(posedge clk);
        model_step(st, hr, rs, ren);
        #1;
        if (m_valid) begin
            check_val("state", bus.state, m_state);
            check_val("cycles", bus.cycles, m_cycles);
            check_val("halt", bus.halt, (m_state >= 3) ? 1 : 0);
            check_val("timeout", bus.timeout, (m_state == 4) ? 1 : 0);
        end
    endtask

    // Free-run (step_mode=0) until the model count reaches target, bounded.
    task automatic advance_to(input int target);
        int budget = 0;
        while ((m_cycles != target) && (budget < 3000)) begin
            cycle(0, 0, 0, 0, 0);
            budget++;
        end
        check_val("reach_cycles", bus.cycles, target);
    endtask

    task automatic restart();
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.step_mode  = 1'b0;
        bus.step_pulse = 1'b0;
        bus.halt_req   = 1'b0;

        // Reset state.
        cycle(0, 0, 0, 0, 1);
        check_val("rst_state", bus.state, 0);
        check_val("rst_cycles", bus.cycles, 0);
        check_val("rst_halt", bus.halt, 0);
        check_val("rst_timeout", bus.timeout, 0);

        // Free run, halt at cycles=10, drain 4 -> halted at 15.
        cycle(1, 0, 0, 0, 0);
        advance_to(10);
        cycle(0, 0, 0, 1, 0);
        check_val("drain_entry", bus.state, 2);
        repeat (8) cycle(0, 0, 0, 0, 0);
        check_val("halt_final", bus.halt, 1);
        check_val("halt_cycles", bus.cycles, 15);
        check_val("halt_no_to", bus.timeout, 0);
        check_val("halt_run_en", bus.run_en, 0);

        // Step mode: three spaced pulses, then halt_req without and with a pulse.
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0);
        repeat (3) begin
            cycle(0, 1, 1, 0, 0);
            repeat (4) cycle(0, 1, 0, 0, 0);
        end
        check_val("step_cycles", bus.cycles, 3);
        repeat (4) cycle(0, 1, 0, 1, 0);
        check_val("step_hr_ignored", bus.state, 1);
        check_val("step_hr_cycles", bus.cycles, 3);
        cycle(0, 1, 1, 1, 0);
        check_val("step_hr_taken", bus.state, 2);
        repeat (6) cycle(0, 1, 0, 0, 0);
        check_val("step_halted", bus.state, 3);
        check_val("step_final_cycles", bus.cycles, 8);

        // Watchdog timeout with no halt.
        restart();
        advance_to(MaxCyc);
        check_val("to_state", bus.state, 4);
        check_val("to_flag", bus.timeout, 1);
        check_val("to_halt", bus.halt, 1);
        repeat (20) cycle(0, 0, 0, 0, 0);
        check_val("to_frozen", bus.cycles, MaxCyc);

        // halt_req on the limit edge -> timeout wins.
        restart();
        advance_to(MaxCyc - 1);
        cycle(0, 0, 0, 1, 0);
        check_val("hr_at_limit_state", bus.state, 4);
        check_val("hr_at_limit_to", bus.timeout, 1);

        // Halt at 847 -> watchdog fires during drain.
        restart();
        advance_to(MaxCyc - 3);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check_val("drain_pre_to", bus.state, 2);
        cycle(0, 0, 0, 0, 0);
        check_val("drain_to_state", bus.state, 4);
        check_val("drain_to_flag", bus.timeout, 1);
        check_val("drain_to_cycles", bus.cycles, MaxCyc);

        // Reset during the second drain cycle, then a clean rerun.
        restart();
        advance_to(5);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check_val("second_drain", bus.state, 2);
        cycle(0, 0, 0, 0, 1);
        check_val("mid_rst_state", bus.state, 0);
        check_val("mid_rst_cycles", bus.cycles, 0);
        check_val("mid_rst_halt", bus.halt, 0);
        cycle(1, 0, 0, 0, 0);
        advance_to(3);
        cycle(0, 0, 0, 1, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        check_val("rerun_state", bus.state, 3);
        check_val("rerun_cycles", bus.cycles, 8);

        // HALTED is sticky against start and halt_req.
        repeat (10) cycle(1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), 0);
        check_val("sticky_state", bus.state, 3);
        check_val("sticky_cycles", bus.cycles, 8);
        check_val("sticky_run_en", bus.run_en, 0);

        // Randomized segments with varying halt density.
        for (int seg = 0; seg < 6; seg++) begin
            int hr_div = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 20 : 200);
            bit sm = 1'b0;
            cycle(0, 0, 0, 0, 1);
            for (int i = 0; i < 1000; i++) begin
                bit rs = ($urandom_range(0, 499) == 0);
                bit st = ($urandom_range(0, 3) == 0);
                bit sp = ($urandom_range(0, 2) == 0);
                bit hr = (hr_div != 0) && ($urandom_range(0, hr_div - 1) == 0);
                if ($urandom_range(0, 49) == 0) sm = ~sm;
                cycle(st, sm, sp, hr, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Synthesizable run/halt sequencer for the pipelined processor. Replaces the free-running simulation halt path with a controlled run sequence: start, optional single-step, pipeline drain after a halt instruction, and a bounded cycle watchdog. Drives the pipeline-wide advance enable and the final halt/timeout indications consumed by the clock/testbench wrapper.

Parameters:
CYCLE_W, 16, width of the executed-cycle counter
MAX_CYCLES, 850, watchdog limit on counted cycles; reaching it forces TIMEOUT (must be < 2**CYCLE_W)
DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after halt_req so in-flight instructions retire (must be >= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  level/pulse; leaves IDLE and begins execution
step_mode  input  1  1 = pipeline advances only on step_pulse while in RUN
step_pulse  input  1  one-cycle advance request, honoured only in RUN with step_mode=1
halt_req  input  1  halt instruction decoded; sampled only in RUN when run_en=1
run_en  output  1  pipeline advance enable (combinational from state and step inputs)
halt  output  1  registered; 1 in HALTED and TIMEOUT
timeout  output  1  registered; 1 only in TIMEOUT
cycles  output  CYCLE_W  count of cycles with run_en=1
state  output  3  current state encoding, for debug

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, cycles=0, drain counter=0, halt=0, timeout=0; run_en=0. Reset is honoured in every state, including DRAIN and HALTED.
- run_en: IDLE 0; RUN 1 if step_mode=0, else equal to step_pulse; DRAIN 1 (step_mode ignored); HALTED/TIMEOUT 0.
- cycles increments by 1 on every edge where run_en=1; frozen otherwise; never wraps.
- IDLE: start=1 -> RUN. All other inputs are ignored.
- RUN: if run_en=1 and halt_req=1 -> DRAIN, drain counter loaded with DRAIN_CYCLES-1. halt_req is ignored when run_en=0 (stepping, no pulse).
- DRAIN: run_en=1 each cycle; counter decrements; when counter=0 -> HALTED. halt_req and start are ignored.
- HALTED: halt=1, run_en=0; sticky until reset.
- TIMEOUT: halt=1, timeout=1, run_en=0; sticky until reset.
- Watchdog: on any edge where run_en=1 and cycles=MAX_CYCLES-1, cycles becomes MAX_CYCLES and the next state is TIMEOUT. This has priority over halt_req in RUN and over drain completion in DRAIN.
- Latency: halt_req accepted at counted cycle N -> DRAIN active for cycles N+1 through N+DRAIN_CYCLES -> halt=1 from cycle N+DRAIN_CYCLES+1. The final cycles value equals N's count + 1 + DRAIN_CYCLES.
- halt and timeout are registered from the next state, so they rise in the same cycle that the state enters HALTED or TIMEOUT.
- Encoding: IDLE=0, RUN=1, DRAIN=2, HALTED=3, TIMEOUT=4.

Decomposition:
- Shared package: state enum (IDLE/RUN/DRAIN/HALTED/TIMEOUT) and its 3-bit width, plus the default MAX_CYCLES and DRAIN_CYCLES constants, so the testbench and the clock wrapper decode state and limits consistently.
- One natural sub-module: cycle_watchdog. It holds the CYCLE_W counter with enable, freeze-at-limit behaviour and the limit_hit flag.
- FSM and drain counter stay in run_controller.

Test Plan:
- Reset then start=1, step_mode=0, halt_req pulsed in the cycle where cycles=10 -> DRAIN for 4 cycles, halt=1 with cycles=15, timeout=0, run_en=0 thereafter.
- step_mode=1 with 3 step_pulses spaced 5 cycles apart -> run_en high exactly 3 cycles, cycles=3. A halt_req held without a pulse is ignored; with a pulse it is accepted.
- No halt_req, step_mode=0 -> timeout=1 and halt=1 when cycles reaches 850; cycles stays 850 for 20 further cycles.
- halt_req at cycles=849 (same edge as the limit) -> TIMEOUT, not DRAIN. Halt at cycles=847 -> timeout during DRAIN, state=4, timeout=1.
- reset asserted on the second DRAIN cycle -> next cycle state=IDLE, cycles=0, halt=0. A following start resumes normally.
- In HALTED, pulse start and halt_req for 10 cycles -> state stays 3, cycles unchanged, run_en=0.
